// File: rtl/riscv_pkg.sv
// Shared LSU definitions: FSM states, RV32I load/store width codes and the
// response bundle handed to writeback.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        misaligned;
    logic        err;
    logic [31:0] badaddr;
  } lsu_resp_t;

  // Illegal funct3 for the direction, or an address not aligned to the access size.
  function automatic logic lsu_fault(input logic we, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic legal;
    logic mis;
    legal = 1'b0;
    mis   = 1'b0;
    case (f3)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1; mis = a[0]; end
      F3_W:  begin legal = 1'b1; mis = |a; end
      F3_BU: legal = !we;
      F3_HU: begin legal = !we; mis = a[0]; end
      default: legal = 1'b0;
    endcase
    return !legal || mis;
  endfunction

  function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word lane out of a memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] lane;

  assign lane = rdata >> {addr, 3'b000};

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:  result = {{24{lane[7]}}, lane[7:0]};
      F3_H:  result = {{16{lane[15]}}, lane[15:0]};
      F3_W:  result = lane;
      F3_BU: result = {24'd0, lane[7:0]};
      F3_HU: result = {16'd0, lane[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access on a word-aligned data bus with a
// bus timeout, alignment checking and load extension.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a request; req_ready high
//   ST_MEM  | mem_req held until mem_ack or timer terminal count
//   ST_RESP | resp_valid pulse for one cycle, then back to IDLE
module lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_err,
  output logic [31:0] resp_badaddr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [3:0]  be_q;
  logic        mis_q;
  logic        err_q;
  logic [TW-1:0] timer;

  logic        fault;
  logic        in_mem;
  logic [31:0] wdata_rep;
  logic [31:0] ld_data;
  lsu_resp_t   resp;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign in_mem    = (state == ST_MEM);
  assign fault     = lsu_fault(req_we, req_funct3, req_addr[1:0]);

  always_comb begin
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00:   wdata_rep = {4{req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  load_align u_load_align (
    .rdata  (mem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .result (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      be_q    <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      timer   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            f3_q    <= req_funct3;
            be_q    <= fault ? 4'b0000 : lsu_be(req_funct3, req_addr[1:0]);
            wdata_q <= wdata_rep;
            rdata_q <= '0;
            mis_q   <= fault;
            err_q   <= 1'b0;
            timer   <= TW'(TIMEOUT - 1);
            state   <= fault ? ST_RESP : ST_MEM;
          end
        end
        ST_MEM: begin
          // An ack on the terminal-count cycle still completes normally.
          if (mem_ack) begin
            rdata_q <= we_q ? 32'd0 : ld_data;
            state   <= ST_RESP;
          end else if (timer == '0) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = in_mem;
  assign mem_we    = in_mem && we_q;
  assign mem_addr  = in_mem ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = in_mem ? be_q : 4'b0000;
  assign mem_wdata = in_mem ? wdata_q : 32'd0;

  assign resp.valid      = (state == ST_RESP);
  assign resp.rdata      = rdata_q;
  assign resp.misaligned = mis_q;
  assign resp.err        = err_q;
  assign resp.badaddr    = addr_q;

  assign resp_valid      = resp.valid;
  assign resp_rdata      = resp.rdata;
  assign resp_misaligned = resp.misaligned;
  assign resp_err        = resp.err;
  assign resp_badaddr    = resp.badaddr;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum MEM-state cycles without mem_ack before a bus error is reported.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  execute stage presents a load/store.
REQ-005 SHALL have port req_ready  output  1  lsu accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width/sign code (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-justified.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse to writeback.
REQ-011 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-012 SHALL have port resp_misaligned  output  1  address misaligned or funct3 illegal, valid with resp_valid.
REQ-013 SHALL have port resp_err  output  1  bus timeout, valid with resp_valid.
REQ-014 SHALL have port resp_badaddr  output  32  captured req_addr, routed to csr mtval.
REQ-015 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_be out 4, mem_wdata out 32, mem_ack in 1, mem_rdata in 32: word-aligned data-memory port.

Function
REQ-016 SHALL implement FSM IDLE -> MEM -> RESP -> IDLE; IDLE -> RESP directly on fault.
REQ-017 SHALL assert req_ready only in IDLE; request accepted when req_valid && req_ready; all request fields captured on acceptance.
REQ-018 SHALL flag misaligned: half with addr[0]=1; word with addr[1:0]!=0; funct3 outside legal set for direction; faulting requests issue no memory access.
REQ-019 SHALL drive mem_req=1 continuously in MEM, with mem_addr={addr[31:2],2'b00} and mem_we, mem_be, mem_wdata held stable until mem_ack.
REQ-020 SHALL generate byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads use the same mask.
REQ-021 SHALL replicate store data across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}.
REQ-022 SHALL, on mem_ack in MEM, select the addressed lane from mem_rdata, sign-extend (LB/LH) or zero-extend (LBU/LHU), register the result, then enter RESP.
REQ-023 SHALL count MEM cycles; when TIMEOUT cycles pass without mem_ack, set resp_err=1, drop mem_req, and enter RESP; mem_ack arriving in the same cycle as expiry takes priority (normal completion).
REQ-024 SHALL assert resp_valid for exactly one cycle in RESP; minimum latency is acceptance -> resp_valid two cycles later when mem_ack arrives in the first MEM cycle.
REQ-025 SHALL ignore mem_ack outside MEM.
REQ-026 SHALL hold resp_rdata, resp_misaligned, resp_err, and resp_badaddr stable from RESP until the next acceptance.

Reset
REQ-027 SHALL, on rst, enter IDLE immediately and clear all outputs to 0, except req_ready, which is 1 once rst deasserts.
REQ-028 SHALL abandon an in-flight MEM access on reset, with no resp_valid generated for it.

Structure
REQ-029 SHALL place the FSM state enum, funct3 width codes, and the lsu-to-writeback response struct in shared package riscv_pkg.
REQ-030 SHALL implement lane select and extension in combinational sub-module load_align (inputs: rdata, addr[1:0], funct3; output: 32-bit result).

Verification
REQ-031 SHALL cover: SW addr 0x0000_0010, wdata 0xDEADBEEF, ack in first cycle -> mem_be=1111, mem_addr=0x10, resp_valid two cycles after acceptance, resp_rdata=0.
REQ-032 SHALL cover: LB addr 0x13, mem_rdata 0x80FF_0000 -> resp_rdata=0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
REQ-033 SHALL cover: SH addr 0x22, wdata 0x0000_1234 -> mem_be=1100, mem_wdata=0x1234_1234.
REQ-034 SHALL cover: LW addr 0x06 -> no mem_req, resp_misaligned=1, resp_badaddr=0x06, resp_valid one cycle after acceptance.
REQ-035 SHALL cover: LH addr 0x40, mem_ack never asserted, TIMEOUT=16 -> resp_err=1 after 16 MEM cycles and mem_req deasserted.
REQ-036 SHALL cover: rst asserted during MEM -> mem_req=0 immediately, no resp_valid, and req_ready=1 after rst release.
